alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Handshaked issue-and-capture stage wrapped around the combinational `ALU_N`. It accepts operation requests (A, B, SELECT) over a valid/ready interface and drives registered operands into the ALU. It captures the ALU result and flags into an output register held under valid/ready backpressure. It also keeps sticky flags, an op counter, and a result-chaining path so back-to-back dependent operations need no external feedback.

## Interface
- N, 3, operand/result width; must equal the width parameter of the attached `ALU_N`
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- IN_VALID  in  1  request valid
- IN_READY  out  1  request accepted when IN_VALID & IN_READY at a rising edge
- IN_A  in  N  operand A
- IN_B  in  N  operand B
- IN_SELECT  in  4  ALU opcode (0000 sum … 1001 shift-right-arith)
- IN_CHAIN  in  1  1 = use last captured result instead of IN_A
- CLEAR  in  1  clear STICKY_FLAGS
- ALU_A  out  N  to ALU_N A
- ALU_B  out  N  to ALU_N B
- ALU_SELECT  out  4  to ALU_N SELECT
- ALU_OUT  in  N  from ALU_N OUT
- ALU_FLAGS  in  4  from ALU_N {FLAG_CARRY, FLAG_OVERFLOW, FLAG_NEGATIVE, FLAG_ZERO}
- OUT_VALID  out  1  result valid
- OUT_READY  in  1  consumer ready
- OUT_RESULT  out  N  captured result
- OUT_FLAGS  out  4  captured {C,V,N,Z}
- OUT_ILLEGAL  out  1  captured op had SELECT > 4'b1001
- STICKY_FLAGS  out  4  OR of all captured flags since reset/CLEAR
- OP_COUNT  out  8  completed-capture count, wraps

## Operation
- States: IDLE, EXEC, HOLD.
- IN_READY:
  - 0 while RESET is high or in EXEC.
  - 1 in IDLE.
  - Equal to OUT_READY in HOLD.
- Accept (IN_VALID & IN_READY at edge):
  - Register opA = IN_CHAIN ? last_result : IN_A, plus opB = IN_B and sel = IN_SELECT.
  - Go to EXEC.
- ALU_A/ALU_B/ALU_SELECT are driven directly from opA/opB/sel registers, so the ALU inputs are glitch-free. They hold their values between ops.
- EXEC (exactly one cycle), at the closing edge:
  - OUT_RESULT <= ALU_OUT; OUT_FLAGS <= ALU_FLAGS; OUT_ILLEGAL <= (sel > 4'b1001).
  - last_result <= ALU_OUT.
  - STICKY_FLAGS |= ALU_FLAGS.
  - OP_COUNT += 1, wrapping 255 -> 0.
  - OUT_VALID <= 1; go to HOLD.
- HOLD, at an edge with OUT_READY = 1:
  - If IN_VALID: accept the new request and go to EXEC; OUT_VALID drops.
  - Otherwise: go to IDLE; OUT_VALID drops.
  - A chained request accepted in HOLD uses the result being handed off.
- HOLD with OUT_READY = 0: OUT_RESULT, OUT_FLAGS and OUT_ILLEGAL stay stable; nothing is accepted.
- Illegal SELECT: forwarded to the ALU unchanged; result and flags are captured as the ALU produces them; OUT_ILLEGAL = 1.
- CLEAR:
  - Zeroes STICKY_FLAGS at the edge.
  - CLEAR coincident with a capture: STICKY_FLAGS <= ALU_FLAGS (clear first, then merge).
  - CLEAR does not affect any other state.
- IN_CHAIN with no prior capture since reset uses last_result = 0.

## Timing
- Reset values: state IDLE, OUT_VALID 0, OUT_RESULT 0, OUT_FLAGS 0, OUT_ILLEGAL 0, STICKY_FLAGS 0, OP_COUNT 0, last_result 0, ALU_A/ALU_B/ALU_SELECT 0.
- Latency:
  - Accept at edge t.
  - Capture at edge t+1.
  - OUT_VALID is high in the cycle after t+1.
- Throughput: one op per 2 cycles with OUT_READY held high and IN_VALID held high.
- RESET mid-operation (EXEC or HOLD):
  - The in-flight op is discarded with no capture and no count.
  - All registers take reset values at that edge.
- The ALU combinational path must settle within one CLK period (opA register -> ALU_N -> capture register).

## Test plan
- Single sum, N=3: A=101, B=001, SELECT=0000.
  - Response: OUT_VALID high 2 cycles after accept, OUT_RESULT=110, OUT_FLAGS=0010, OP_COUNT=1.
- Chain: the previous op is followed in HOLD by IN_CHAIN=1, B=010, SELECT=0000, with OUT_READY=1.
  - Response: accepted that edge, OUT_RESULT=000, OUT_FLAGS C=1 Z=1, STICKY_FLAGS=1011.
- Overflow then CLEAR: 011+001 gives OUT_RESULT=100 with V=1, N=1.
  - Pulse CLEAR alone -> STICKY_FLAGS=0000.
  - Pulse CLEAR on the capture edge of 010+000 -> STICKY_FLAGS=0000 (Z=0, since the result 010 is nonzero).
- Backpressure: OUT_READY=0 for 5 cycles with IN_VALID held.
  - Response: OUT_RESULT stable, IN_READY=0, no new accept.
  - OUT_READY=1 -> request accepted that edge, OUT_VALID low next cycle.
- Illegal op: SELECT=1111 -> OUT_ILLEGAL=1 and OP_COUNT increments; the next legal op -> OUT_ILLEGAL=0.
- Reset and wrap:
  - RESET asserted during EXEC -> no capture, OP_COUNT=0, OUT_VALID=0.
  - 256 completed ops -> OP_COUNT returns to 0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Purpose: handshaked issue/capture stage around a combinational ALU_N, with sticky flags, op count and result chaining.
// Latency: accept at edge t, capture at edge t+1, OUT_VALID high from the cycle after t+1; one op per 2 cycles.
// Backpressure: HOLD keeps the captured result until OUT_READY; IN_READY follows OUT_READY in HOLD, low in EXEC.
module alu_op_sequencer #(
  parameter int N = 3
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [N-1:0] IN_A,
  input  logic [N-1:0] IN_B,
  input  logic [3:0]   IN_SELECT,
  input  logic         IN_CHAIN,
  input  logic         CLEAR,
  output logic [N-1:0] ALU_A,
  output logic [N-1:0] ALU_B,
  output logic [3:0]   ALU_SELECT,
  input  logic [N-1:0] ALU_OUT,
  input  logic [3:0]   ALU_FLAGS,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [N-1:0] OUT_RESULT,
  output logic [3:0]   OUT_FLAGS,
  output logic         OUT_ILLEGAL,
  output logic [3:0]   STICKY_FLAGS,
  output logic [7:0]   OP_COUNT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [3:0] LAST_LEGAL_SEL = 4'b1001;

  state_t       state;
  logic [N-1:0] last_result;
  logic         accept;

  // Ready is combinational so a HOLD slot can hand off and accept in the same edge.
  always_comb begin
    IN_READY = 1'b0;
    if (!RESET) begin
      case (state)
        IDLE:    IN_READY = 1'b1;
        HOLD:    IN_READY = OUT_READY;
        default: IN_READY = 1'b0;
      endcase
    end
  end

  assign accept = IN_VALID & IN_READY;

  // Sequencer FSM with registered ALU operands, capture registers, sticky flags and op counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      ALU_A        <= '0;
      ALU_B        <= '0;
      ALU_SELECT   <= '0;
      last_result  <= '0;
      OUT_VALID    <= 1'b0;
      OUT_RESULT   <= '0;
      OUT_FLAGS    <= '0;
      OUT_ILLEGAL  <= 1'b0;
      STICKY_FLAGS <= '0;
      OP_COUNT     <= '0;
    end else begin
      // CLEAR outside a capture edge simply zeroes the sticky set.
      if (CLEAR) begin
        STICKY_FLAGS <= '0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            ALU_A      <= IN_CHAIN ? last_result : IN_A;
            ALU_B      <= IN_B;
            ALU_SELECT <= IN_SELECT;
            state      <= EXEC;
          end
        end
        EXEC: begin
          OUT_RESULT   <= ALU_OUT;
          OUT_FLAGS    <= ALU_FLAGS;
          OUT_ILLEGAL  <= (ALU_SELECT > LAST_LEGAL_SEL);
          last_result  <= ALU_OUT;
          // Clear takes effect before this capture's flags are merged in.
          STICKY_FLAGS <= (CLEAR ? 4'b0000 : STICKY_FLAGS) | ALU_FLAGS;
          OP_COUNT     <= OP_COUNT + 8'd1;
          OUT_VALID    <= 1'b1;
          state        <= HOLD;
        end
        HOLD: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            if (IN_VALID) begin
              // last_result equals the result being handed off this edge.
              ALU_A      <= IN_CHAIN ? last_result : IN_A;
              ALU_B      <= IN_B;
              ALU_SELECT <= IN_SELECT;
              state      <= EXEC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Purpose: bench for alu_op_sequencer with an ALU stand-in and a transaction-level expectation model.
// Latency: checks accept -> EXEC -> capture timing on every op.
// Backpressure: exercises OUT_READY stalls with a pending request held.
module tb_alu_op_sequencer;
  localparam int N = 3;

  logic         CLK;
  logic         RESET;
  logic         IN_VALID;
  logic         IN_READY;
  logic [N-1:0] IN_A;
  logic [N-1:0] IN_B;
  logic [3:0]   IN_SELECT;
  logic         IN_CHAIN;
  logic         CLEAR;
  logic [N-1:0] ALU_A;
  logic [N-1:0] ALU_B;
  logic [3:0]   ALU_SELECT;
  logic [N-1:0] ALU_OUT;
  logic [3:0]   ALU_FLAGS;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [N-1:0] OUT_RESULT;
  logic [3:0]   OUT_FLAGS;
  logic         OUT_ILLEGAL;
  logic [3:0]   STICKY_FLAGS;
  logic [7:0]   OP_COUNT;

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected architectural state, tracked per completed transaction.
  logic [N-1:0] m_last;
  logic [N-1:0] m_res;
  logic [3:0]   m_flg;
  logic         m_ill;
  logic [3:0]   m_sticky;
  int           m_count;

  alu_op_sequencer #(.N(N)) dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_A(IN_A), .IN_B(IN_B), .IN_SELECT(IN_SELECT), .IN_CHAIN(IN_CHAIN),
    .CLEAR(CLEAR), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_SELECT(ALU_SELECT),
    .ALU_OUT(ALU_OUT), .ALU_FLAGS(ALU_FLAGS), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUT_RESULT(OUT_RESULT), .OUT_FLAGS(OUT_FLAGS),
    .OUT_ILLEGAL(OUT_ILLEGAL), .STICKY_FLAGS(STICKY_FLAGS), .OP_COUNT(OP_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Arithmetic definition of the ALU: returns {C,V,N,Z,result}.
  function automatic logic [N+3:0] alu_f(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [3:0] sel);
    logic [N:0]   w;
    logic [N-1:0] r;
    logic         c;
    logic         v;
    c = 1'b0;
    v = 1'b0;
    w = '0;
    case (sel)
      4'd0: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[N-1:0];
        c = w[N];
        v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
      end
      4'd1: begin
        w = {1'b0, a} - {1'b0, b};
        r = w[N-1:0];
        c = w[N];
        v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: r = a << 1;
      4'd7: r = a >> 1;
      4'd8: r = a + 1'b1;
      4'd9: r = $signed(a) >>> 1;
      default: r = a ^ ~b;
    endcase
    return {c, v, r[N-1], (r == '0), r};
  endfunction

  // Stand-in for the attached combinational ALU_N.
  always_comb begin
    {ALU_FLAGS, ALU_OUT} = alu_f(ALU_A, ALU_B, ALU_SELECT);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One full transaction: requires IN_READY high now; checks EXEC cycle and capture.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] sel,
                       input logic chain, input logic clr);
    logic [N-1:0] opa;
    logic [N+3:0] r;
    IN_A = a; IN_B = b; IN_SELECT = sel; IN_CHAIN = chain; IN_VALID = 1'b1;
    #1;
    chk("ready_before_accept", IN_READY, 1);
    opa = chain ? m_last : a;
    tick();
    IN_VALID = 1'b0;
    IN_CHAIN = 1'b0;
    chk("valid_in_exec", OUT_VALID, 0);
    chk("ready_in_exec", IN_READY, 0);
    chk("alu_a", ALU_A, opa);
    chk("alu_b", ALU_B, b);
    chk("alu_sel", ALU_SELECT, sel);
    CLEAR = clr;
    tick();
    CLEAR = 1'b0;
    r        = alu_f(opa, b, sel);
    m_res    = r[N-1:0];
    m_flg    = r[N+3:N];
    m_ill    = (sel > 4'd9);
    m_last   = m_res;
    m_sticky = (clr ? 4'b0000 : m_sticky) | m_flg;
    m_count  = (m_count + 1) % 256;
    chk("valid_after_capture", OUT_VALID, 1);
    chk("result", OUT_RESULT, m_res);
    chk("flags", OUT_FLAGS, m_flg);
    chk("illegal", OUT_ILLEGAL, m_ill);
    chk("op_count", OP_COUNT, m_count);
    chk("sticky", STICKY_FLAGS, m_sticky);
  endtask

  // Hold the output for n cycles with a different request pending.
  task automatic stall(input int n);
    OUT_READY = 1'b0;
    IN_VALID  = 1'b1;
    IN_A = N'($urandom); IN_B = N'($urandom); IN_SELECT = 4'($urandom);
    for (int i = 0; i < n; i++) begin
      #1;
      chk("stall_ready", IN_READY, 0);
      tick();
      chk("stall_valid", OUT_VALID, 1);
      chk("stall_result", OUT_RESULT, m_res);
      chk("stall_flags", OUT_FLAGS, m_flg);
      chk("stall_count", OP_COUNT, m_count);
    end
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
  endtask

  // Hand the result off with no new request; the block returns to idle.
  task automatic drain();
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    tick();
    chk("drain_valid", OUT_VALID, 0);
    chk("drain_ready", IN_READY, 1);
  endtask

  task automatic model_reset();
    m_last = '0; m_res = '0; m_flg = '0; m_ill = 1'b0; m_sticky = '0; m_count = 0;
  endtask

  initial begin
    int c0;
    RESET = 1'b1; IN_VALID = 1'b0; IN_A = '0; IN_B = '0; IN_SELECT = '0;
    IN_CHAIN = 1'b0; CLEAR = 1'b0; OUT_READY = 1'b1;
    model_reset();
    tick();
    tick();
    chk("ready_in_reset", IN_READY, 0);
    RESET = 1'b0;
    #1;
    chk("rst_valid", OUT_VALID, 0);
    chk("rst_result", OUT_RESULT, 0);
    chk("rst_flags", OUT_FLAGS, 0);
    chk("rst_illegal", OUT_ILLEGAL, 0);
    chk("rst_sticky", STICKY_FLAGS, 0);
    chk("rst_count", OP_COUNT, 0);
    chk("rst_alu_a", ALU_A, 0);
    chk("rst_alu_sel", ALU_SELECT, 0);
    chk("rst_ready", IN_READY, 1);

    // Single sum 101 + 001.
    issue(3'b101, 3'b001, 4'b0000, 1'b0, 1'b0);
    chk("sum_result", OUT_RESULT, 3'b110);
    chk("sum_flags", OUT_FLAGS, 4'b0010);
    chk("sum_count", OP_COUNT, 1);

    // Chained add accepted straight out of HOLD.
    issue(3'b000, 3'b010, 4'b0000, 1'b1, 1'b0);
    chk("chain_result", OUT_RESULT, 3'b000);
    chk("chain_flags", OUT_FLAGS, 4'b1001);
    chk("chain_sticky", STICKY_FLAGS, 4'b1011);
    drain();

    // Overflow, CLEAR alone, then CLEAR on a capture edge.
    issue(3'b011, 3'b001, 4'b0000, 1'b0, 1'b0);
    chk("ovf_result", OUT_RESULT, 3'b100);
    chk("ovf_flags", OUT_FLAGS, 4'b0110);
    drain();
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    m_sticky = 4'b0000;
    chk("clear_alone", STICKY_FLAGS, 4'b0000);
    chk("clear_keeps_count", OP_COUNT, m_count);
    issue(3'b010, 3'b000, 4'b0000, 1'b0, 1'b1);
    chk("clear_on_capture", STICKY_FLAGS, 4'b0000);

    // Backpressure for 5 cycles, then release with a request pending.
    stall(5);
    issue(3'b001, 3'b110, 4'b0001, 1'b0, 1'b0);

    // Illegal select, followed by a legal one.
    issue(3'b110, 3'b011, 4'b1111, 1'b0, 1'b0);
    chk("illegal_set", OUT_ILLEGAL, 1);
    issue(3'b110, 3'b011, 4'b0010, 1'b0, 1'b0);
    chk("illegal_clr", OUT_ILLEGAL, 0);
    drain();

    // Reset while in EXEC discards the op.
    IN_A = 3'b111; IN_B = 3'b111; IN_SELECT = 4'd0; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    model_reset();
    chk("exec_rst_valid", OUT_VALID, 0);
    chk("exec_rst_count", OP_COUNT, 0);
    chk("exec_rst_result", OUT_RESULT, 0);
    chk("exec_rst_sticky", STICKY_FLAGS, 0);
    chk("exec_rst_alu_a", ALU_A, 0);
    tick();
    chk("exec_rst_no_capture", OUT_VALID, 0);

    // Chain with no capture since reset uses zero.
    issue(3'b111, 3'b011, 4'b0000, 1'b1, 1'b0);
    chk("chain_zero", OUT_RESULT, 3'b011);

    // Reset while in HOLD.
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    model_reset();
    chk("hold_rst_valid", OUT_VALID, 0);
    chk("hold_rst_count", OP_COUNT, 0);

    // 256 randomized ops with stalls and drains; count must wrap back.
    c0 = m_count;
    for (int i = 0; i < 256; i++) begin
      issue(N'($urandom), N'($urandom), 4'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 5) == 0) stall($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) drain();
    end
    chk("wrap_count", OP_COUNT, c0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
